// File: rtl/cache_line_evictor.sv
// Streams one cache line out of the data array to memory, one word per
// READ/SEND pair, with a one-cycle done pulse once the final beat is accepted.
module cache_line_evictor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned SET_SIZE       = 2,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned ASSOC          = 1,
  localparam int unsigned WSEL = $clog2(WORDS_PER_LINE),
  localparam int unsigned WAYW = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  localparam int unsigned TAGW = XLEN - SET_SIZE - WSEL - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                evict_req,
  input  logic [SET_SIZE-1:0] evict_set,
  input  logic [WAYW-1:0]     evict_way,
  input  logic [TAGW-1:0]     evict_tag,
  output logic                evict_busy,
  output logic                evict_done,
  output logic [SET_SIZE-1:0] dl_set,
  output logic [WAYW-1:0]     dl_way,
  output logic [WSEL-1:0]     dl_word_select,
  input  logic [XLEN-1:0]     dl_fetched_word,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic                mem_last
);

  localparam logic [WSEL-1:0] LAST_WORD = WSEL'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [TAGW-1:0] tag_q;

  // The latched set/way and word counter drive the data-array read port directly.
  assign mem_addr = {tag_q, dl_set, dl_word_select, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tag_q          <= '0;
      dl_set         <= '0;
      dl_way         <= '0;
      dl_word_select <= '0;
      mem_wdata      <= '0;
      mem_valid      <= 1'b0;
      mem_last       <= 1'b0;
      evict_busy     <= 1'b0;
      evict_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (evict_req) begin
            tag_q          <= evict_tag;
            dl_set         <= evict_set;
            dl_way         <= evict_way;
            dl_word_select <= '0;
            evict_busy     <= 1'b1;
            state          <= READ;
          end
        end
        READ: begin
          mem_wdata <= dl_fetched_word;
          mem_valid <= 1'b1;
          mem_last  <= (dl_word_select == LAST_WORD);
          state     <= SEND;
        end
        SEND: begin
          // Beat is held unchanged until the memory accepts it.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_last  <= 1'b0;
            if (dl_word_select == LAST_WORD) begin
              evict_done <= 1'b1;
              state      <= DONE;
            end else begin
              dl_word_select <= dl_word_select + WSEL'(1);
              state          <= READ;
            end
          end
        end
        DONE: begin
          evict_done <= 1'b0;
          evict_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_evictor.sv
// Randomized bench for cache_line_evictor: a per-line reference model predicts
// every beat, the read-port values and the done cycle from the eviction request.
module tb_cache_line_evictor;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned SET_SIZE = 2;
  localparam int unsigned ASSOC    = 4;
  localparam int unsigned WSEL     = 3;
  localparam int unsigned WAYW     = 2;
  localparam int unsigned TAGW     = XLEN - SET_SIZE - WSEL - 2;
  localparam int          WPL      = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                evict_req;
  logic [SET_SIZE-1:0] evict_set;
  logic [WAYW-1:0]     evict_way;
  logic [TAGW-1:0]     evict_tag;
  logic                evict_busy;
  logic                evict_done;
  logic [SET_SIZE-1:0] dl_set;
  logic [WAYW-1:0]     dl_way;
  logic [WSEL-1:0]     dl_word_select;
  logic [XLEN-1:0]     dl_fetched_word;
  logic                mem_valid;
  logic                mem_ready;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_last;

  logic [XLEN-1:0] salt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Data array: word w of way v holds 0xA0 + w + 256*v, optionally scrambled by salt.
  assign dl_fetched_word = salt ^ (32'hA0 + 32'(dl_word_select) + (32'(dl_way) << 8));

  cache_line_evictor #(
    .XLEN(XLEN), .SET_SIZE(SET_SIZE), .WORDS_PER_LINE(WPL), .ASSOC(ASSOC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_req(evict_req), .evict_set(evict_set), .evict_way(evict_way), .evict_tag(evict_tag),
    .evict_busy(evict_busy), .evict_done(evict_done),
    .dl_set(dl_set), .dl_way(dl_way), .dl_word_select(dl_word_select),
    .dl_fetched_word(dl_fetched_word),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_last(mem_last)
  );

  // Runs one line eviction and checks it beat by beat against the reference model.
  task automatic do_line(input logic [SET_SIZE-1:0] s, input logic [WAYW-1:0] wy,
                         input logic [TAGW-1:0] tg, input int stall_beat, input int stall_len,
                         input bit rnd_ready, input bit disturb, input bit hold,
                         input int abort_beat);
    int idx = 0;
    int cyc = 1;
    int stalls = 0;
    int stalled = 0;
    bit done_seen = 1'b0;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] ed;
    logic el;
    logic rdy;
    @(negedge clk);
    evict_req = 1'b1;
    evict_set = s;
    evict_way = wy;
    evict_tag = tg;
    mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        if (disturb && idx < WPL - 2) begin
          evict_req = 1'($urandom_range(0, 1));
          evict_set = SET_SIZE'($urandom);
          evict_way = WAYW'($urandom);
          evict_tag = TAGW'($urandom);
        end else begin
          evict_req = 1'b0;
        end
      end
      checks++;
      if (evict_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy: cycle %0d evict_busy=%b expected 1", cyc, evict_busy);
      end
      if (mem_valid === 1'b1) begin
        ea = (XLEN'(tg) << (SET_SIZE + WSEL + 2)) | (XLEN'(s) << (WSEL + 2)) | XLEN'(idx * 4);
        ed = salt ^ (32'hA0 + 32'(idx) + (32'(wy) << 8));
        el = (idx == WPL - 1);
        checks++;
        if (idx >= WPL || mem_addr !== ea || mem_wdata !== ed || mem_last !== el
            || evict_done !== 1'b0) begin
          errors++;
          $display("FAIL beat%0d: addr=%h data=%h last=%b done=%b expected addr=%h data=%h last=%b done=0",
                   idx, mem_addr, mem_wdata, mem_last, evict_done, ea, ed, el);
        end
        if (abort_beat >= 0 && idx == abort_beat) begin
          rst_n = 1'b0;
          evict_req = 1'b0;
          #1;
          checks++;
          if ({evict_busy, evict_done, mem_valid, mem_last} !== 4'b0 || mem_addr !== '0
              || mem_wdata !== '0 || dl_set !== '0 || dl_way !== '0 || dl_word_select !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b valid=%b last=%b addr=%h wdata=%h dl=%h/%h/%h expected all 0",
                     evict_busy, evict_done, mem_valid, mem_last, mem_addr, mem_wdata,
                     dl_set, dl_way, dl_word_select);
          end
          @(negedge clk);
          rst_n = 1'b1;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (evict_done !== 1'b0 || evict_busy !== 1'b0 || mem_valid !== 1'b0) begin
              errors++;
              $display("FAIL post_abort: done=%b busy=%b valid=%b expected 0 0 0",
                       evict_done, evict_busy, mem_valid);
            end
          end
          return;
        end
        if (idx == stall_beat && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end else begin
          rdy = rnd_ready ? (($urandom_range(0, 3)) != 0) : 1'b1;
        end
        mem_ready = rdy;
        if (rdy) idx++;
        else stalls++;
      end else if (evict_done === 1'b1) begin
        checks++;
        if (idx != WPL || cyc != 2 * WPL + 2 + stalls) begin
          errors++;
          $display("FAIL done: cycle=%0d beats=%0d expected cycle=%0d beats=%0d",
                   cyc, idx, 2 * WPL + 2 + stalls, WPL);
        end
        done_seen = 1'b1;
        mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        checks++;
        if (dl_set !== s || dl_way !== wy || dl_word_select !== WSEL'(idx) || mem_last !== 1'b0) begin
          errors++;
          $display("FAIL read%0d: dl_set=%h dl_way=%h word=%h last=%b expected %h %h %h 0",
                   idx, dl_set, dl_way, dl_word_select, mem_last, s, wy, WSEL'(idx));
        end
        mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no evict_done after %0d cycles", cyc);
    end
    if (!hold) begin
      evict_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        checks++;
        if (evict_busy !== 1'b0 || evict_done !== 1'b0 || mem_valid !== 1'b0) begin
          errors++;
          $display("FAIL after_done: busy=%b done=%b valid=%b expected 0 0 0",
                   evict_busy, evict_done, mem_valid);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    evict_req = 1'b0;
    evict_set = '0;
    evict_way = '0;
    evict_tag = '0;
    mem_ready = 1'b1;
    salt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({evict_busy, evict_done, mem_valid, mem_last} !== 4'b0 || mem_addr !== '0
        || mem_wdata !== '0 || dl_set !== '0 || dl_way !== '0 || dl_word_select !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b valid=%b last=%b addr=%h wdata=%h expected all 0",
               evict_busy, evict_done, mem_valid, mem_last, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (evict_busy !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b valid=%b expected 0 0", evict_busy, mem_valid);
    end
  endtask

  task automatic test_single_line;
    salt = '0;
    do_line(2'd2, 2'd0, TAGW'(32'h1234), -1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall;
    salt = '0;
    do_line(2'd1, 2'd0, TAGW'(32'h0ABCD), 3, 5, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_ignore_mid;
    salt = 32'h5A5A_0000;
    do_line(2'd3, 2'd1, TAGW'(32'h15555), -1, 0, 1'b1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_abort;
    salt = '0;
    do_line(2'd2, 2'd2, TAGW'(32'h0777), -1, 0, 1'b0, 1'b0, 1'b0, 4);
    do_line(2'd0, 2'd1, TAGW'(32'h0888), -1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    salt = 32'h0001_0000;
    do_line(2'd1, 2'd2, TAGW'(32'h0321), -1, 0, 1'b0, 1'b0, 1'b1, -1);
    do_line(2'd1, 2'd2, TAGW'(32'h0321), -1, 0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_way3;
    salt = '0;
    do_line(2'd0, 2'd3, TAGW'(32'h1F00F), 6, 2, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      salt = $urandom;
      do_line(SET_SIZE'($urandom), WAYW'($urandom), TAGW'($urandom),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              1'b1, 1'($urandom_range(0, 1)), 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_stall();
    test_ignore_mid();
    test_reset_abort();
    test_back_to_back();
    test_way3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
